// File: rtl/matrix_loader_pkg.sv
// Shared constants, state encoding and start-validation helper for the matrix loader.
package matrix_loader_pkg;

  localparam int ML_ADDR_W          = 24;
  localparam int ML_RAM_AW          = 10;
  localparam int ML_MAX_DIMENSION   = 32;
  localparam int ML_MAX_OUTSTANDING = 8;
  localparam int DIM_W              = 6;
  localparam int CNT_W              = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  function automatic logic dim_ok(input logic [DIM_W-1:0] dim, input int max_dim);
    return (int'(dim) >= 2) && (int'(dim) <= max_dim);
  endfunction

endpackage

// File: rtl/matrix_loader.sv
// Streams an n x n row-major matrix of 32-bit words from an Avalon-MM read port
// into an external RAM at word addresses 0..n*n-1, keeping a bounded number of reads in flight.
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int ADDR_W          = ML_ADDR_W,
  parameter int RAM_AW          = ML_RAM_AW,
  parameter int MAX_DIMENSION   = ML_MAX_DIMENSION,
  parameter int MAX_OUTSTANDING = ML_MAX_OUTSTANDING
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  dimension,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  input  logic [31:0]       readdata,
  input  logic              readdatavalid,
  input  logic              waitrequest,
  output logic [RAM_AW-1:0] ram_wraddress,
  output logic [31:0]       ram_data,
  output logic              ram_wren,
  output state_e            state_dbg
);

  // Avalon handshake: a read is accepted on any rising edge where read=1 and
  // waitrequest=0; while stalled, read and address hold. Each accepted read
  // returns exactly one readdatavalid beat, in order, at least one cycle later.

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  state_e            state_q;
  logic              busy_q, done_q, error_q, read_q, ram_wren_q;
  logic [ADDR_W-1:0] address_q;
  logic [RAM_AW-1:0] ram_wraddress_q;
  logic [31:0]       ram_data_q;
  logic [CNT_W-1:0]  n_q, issued_q, received_q;
  logic [OUT_W-1:0]  outstanding_q;

  logic             accept, rdv_take, read_d;
  logic [CNT_W-1:0] issued_d, received_d, n_d;
  logic [OUT_W-1:0] outstanding_d;

  assign accept        = read_q && !waitrequest;
  // Beats outside an active load, or beyond the N-th, are stale and dropped.
  assign rdv_take      = readdatavalid && (state_q == ST_ISSUE || state_q == ST_DRAIN)
                         && (received_q != n_q);
  assign issued_d      = issued_q + CNT_W'(accept);
  assign received_d    = received_q + CNT_W'(rdv_take);
  assign outstanding_d = outstanding_q + OUT_W'(accept) - OUT_W'(rdv_take);
  assign read_d        = (issued_d != n_q) && (outstanding_d != OUT_W'(MAX_OUTSTANDING));
  assign n_d           = CNT_W'(dimension) * CNT_W'(dimension);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      read_q          <= 1'b0;
      ram_wren_q      <= 1'b0;
      address_q       <= '0;
      ram_wraddress_q <= '0;
      ram_data_q      <= '0;
      n_q             <= '0;
      issued_q        <= '0;
      received_q      <= '0;
      outstanding_q   <= '0;
    end else begin
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      ram_wren_q    <= rdv_take;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      if (rdv_take) begin
        ram_data_q      <= readdata;
        ram_wraddress_q <= received_q[RAM_AW-1:0];
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (dim_ok(dimension, MAX_DIMENSION)) begin
              address_q     <= base_addr;
              n_q           <= n_d;
              issued_q      <= '0;
              received_q    <= '0;
              outstanding_q <= '0;
              read_q        <= 1'b1;
              busy_q        <= 1'b1;
              state_q       <= ST_ISSUE;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          issued_q <= issued_d;
          read_q   <= read_d;
          if (accept) address_q <= address_q + ADDR_W'(4);
          if (issued_d == n_q) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (received_q == n_q) begin
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign address       = address_q;
  assign read          = read_q;
  assign ram_wraddress = ram_wraddress_q;
  assign ram_data      = ram_data_q;
  assign ram_wren      = ram_wren_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: an Avalon slave with configurable latency/stalls, and a
// reference list of expected RAM writes derived from base + 4*i.
module tb_matrix_loader;
  import matrix_loader_pkg::*;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [5:0]    dimension = '0;
  logic          busy, done, error, read, ram_wren;
  logic [AW-1:0] address;
  logic [31:0]   readdata = '0;
  logic          readdatavalid = 1'b0;
  logic          waitrequest = 1'b0;
  logic [9:0]    ram_wraddress;
  logic [31:0]   ram_data;
  state_e        state_dbg;

  matrix_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .dimension(dimension), .busy(busy), .done(done), .error(error),
    .address(address), .read(read), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .ram_wraddress(ram_wraddress), .ram_data(ram_data), .ram_wren(ram_wren),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct { logic [AW-1:0] addr; int due; } pend_t;

  pend_t         pend_q[$];
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_rd_q[$];
  logic [9:0]    obs_wa_q[$];
  logic [31:0]   obs_wd_q[$];
  logic [AW-1:0] acc_addr_q[$];
  logic [AW-1:0] stall_addr_q[$];

  int cycle_cnt = 0;
  int acc_cnt, ret_cnt, peak, done_cnt, err_cnt, read_seen, stall_viol;
  int done_cycle, last_wren_cycle, read_gap;
  int lat, hold_until, wr_target, wr_left;
  bit rand_wait, prev_stall;
  logic [AW-1:0] prev_addr;
  logic [31:0] seed = 32'h5A17_C3E1;
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ seed;
  endfunction

  task automatic clear_obs();
    pend_q.delete(); exp_q.delete(); exp_rd_q.delete();
    obs_wa_q.delete(); obs_wd_q.delete(); acc_addr_q.delete(); stall_addr_q.delete();
    acc_cnt = 0; ret_cnt = 0; peak = 0; done_cnt = 0; err_cnt = 0; read_seen = 0;
    stall_viol = 0; done_cycle = -1; last_wren_cycle = -1; read_gap = 0;
    lat = 2; hold_until = 0; wr_target = -1; wr_left = 0; rand_wait = 0; prev_stall = 0;
    readdatavalid = 1'b0; waitrequest = 1'b0;
  endtask

  task automatic build_expected(input int dim, input logic [AW-1:0] base);
    logic [AW-1:0] a;
    for (int i = 0; i < dim * dim; i++) begin
      a = base + AW'(4 * i);
      exp_rd_q.push_back(a);
      exp_q.push_back(mem_word(a));
    end
  endtask

  // Advances one cycle: samples outputs #1 after the edge, then drives the slave inputs.
  task automatic step();
    pend_t p;
    @(posedge clk); #1;
    cycle_cnt++;
    if (ram_wren) begin
      obs_wa_q.push_back(ram_wraddress);
      obs_wd_q.push_back(ram_data);
      last_wren_cycle = cycle_cnt;
    end
    if (done) begin done_cnt++; done_cycle = cycle_cnt; end
    if (error) err_cnt++;
    if (read) read_seen++;
    if (busy && !read && acc_cnt > 0 && acc_cnt < exp_rd_q.size()) read_gap++;
    if (prev_stall && (!read || address !== prev_addr)) stall_viol++;
    waitrequest = 1'b0;
    if (read) begin
      if (acc_cnt == wr_target && wr_left > 0) begin
        waitrequest = 1'b1;
        wr_left--;
      end else if (rand_wait && $urandom_range(0, 3) == 0) begin
        waitrequest = 1'b1;
      end
    end
    if (read && waitrequest) stall_addr_q.push_back(address);
    prev_stall = read && waitrequest;
    prev_addr  = address;
    if (read && !waitrequest) begin
      acc_addr_q.push_back(address);
      p.addr = address;
      p.due  = cycle_cnt + lat;
      pend_q.push_back(p);
      acc_cnt++;
    end
    readdatavalid = 1'b0;
    readdata      = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cycle_cnt && cycle_cnt >= hold_until) begin
      readdatavalid = 1'b1;
      readdata      = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
      ret_cnt++;
    end
    if (acc_cnt - ret_cnt > peak) peak = acc_cnt - ret_cnt;
  endtask

  task automatic begin_load(input int dim, input logic [AW-1:0] base);
    dimension = 6'(dim);
    base_addr = base;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin step(); n++; end
    repeat (3) step();
  endtask

  function automatic int first_write_bad();
    int n = (obs_wa_q.size() < exp_q.size()) ? obs_wa_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs_wa_q[i] !== 10'(i) || obs_wd_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int first_read_bad();
    int n = (acc_addr_q.size() < exp_rd_q.size()) ? acc_addr_q.size() : exp_rd_q.size();
    for (int i = 0; i < n; i++)
      if (acc_addr_q[i] !== exp_rd_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    reset_n = 1'b1; #1;
    reset_n = 1'b0; #1;
    tests++;
    if ({busy, done, error, read, ram_wren} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, error, read, ram_wren});
    end
    tests++;
    if (address !== '0 || ram_wraddress !== '0 || ram_data !== '0 || state_dbg !== ST_IDLE) begin
      fails++; $display("FAIL reset_values: got addr=%h wa=%h wd=%h st=%0d expected all 0",
                        address, ram_wraddress, ram_data, state_dbg);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int bad;
    clear_obs();
    build_expected(2, 24'h000100);
    begin_load(2, 24'h000100);
    tests++;
    if (!(busy === 1'b1 && read === 1'b1 && address === 24'h000100)) begin
      fails++; $display("FAIL basic_first_read: got busy=%b read=%b addr=%h expected 1 1 000100",
                        busy, read, address);
    end
    run_to_done(200);
    bad = first_read_bad();
    tests++;
    if (acc_addr_q.size() !== 4 || bad !== -1) begin
      fails++; $display("FAIL basic_reads: got %0d reads, first bad %0d, expected 4 reads in order",
                        acc_addr_q.size(), bad);
    end
    bad = first_write_bad();
    tests++;
    if (obs_wa_q.size() !== 4 || bad !== -1) begin
      fails++; $display("FAIL basic_writes: got %0d writes, first bad %0d, expected 4 in order",
                        obs_wa_q.size(), bad);
    end
    tests++;
    if (done_cnt !== 1 || done_cycle !== last_wren_cycle + 1) begin
      fails++; $display("FAIL basic_done: got %0d pulses at cycle %0d expected 1 at cycle %0d",
                        done_cnt, done_cycle, last_wren_cycle + 1);
    end
    tests++;
    if (busy !== 1'b0 || err_cnt !== 0) begin
      fails++; $display("FAIL basic_idle: got busy=%b errors=%0d expected 0 0", busy, err_cnt);
    end
  endtask

  task automatic test_invalid();
    int bad_dims[3] = '{1, 33, 0};
    foreach (bad_dims[k]) begin
      clear_obs();
      begin_load(bad_dims[k], 24'h000200);
      repeat (4) step();
      tests++;
      if (err_cnt !== 1 || read_seen !== 0 || busy !== 1'b0) begin
        fails++; $display("FAIL invalid_dim_%0d: got errors=%0d reads=%0d busy=%b expected 1 0 0",
                          bad_dims[k], err_cnt, read_seen, busy);
      end
    end
  endtask

  task automatic test_waitrequest();
    logic [AW-1:0] base = 24'h0A0040;
    int bad, hold_bad = 0;
    clear_obs();
    wr_target = 1;
    wr_left   = 3;
    build_expected(4, base);
    begin_load(4, base);
    run_to_done(400);
    foreach (stall_addr_q[i]) if (stall_addr_q[i] !== base + 24'd4) hold_bad++;
    tests++;
    if (stall_addr_q.size() !== 3 || hold_bad !== 0 || stall_viol !== 0) begin
      fails++; $display("FAIL wait_hold: got %0d stall cycles, %0d wrong addr, %0d unstable, expected 3 0 0",
                        stall_addr_q.size(), hold_bad, stall_viol);
    end
    bad = first_write_bad();
    tests++;
    if (obs_wa_q.size() !== 16 || bad !== -1 || done_cnt !== 1) begin
      fails++; $display("FAIL wait_writes: got %0d writes, first bad %0d, done %0d expected 16 -1 1",
                        obs_wa_q.size(), bad, done_cnt);
    end
  endtask

  task automatic test_outstanding();
    logic [AW-1:0] base = 24'h012340;
    int bad;
    clear_obs();
    hold_until = cycle_cnt + 21;
    build_expected(32, base);
    begin_load(32, base);
    run_to_done(6000);
    tests++;
    if (peak !== 8 || read_gap == 0) begin
      fails++; $display("FAIL outst_peak: got peak=%0d read_gap=%0d expected peak 8 with gaps", peak, read_gap);
    end
    bad = first_read_bad();
    tests++;
    if (acc_cnt !== 1024 || bad !== -1) begin
      fails++; $display("FAIL outst_reads: got %0d reads first bad %0d expected 1024 -1", acc_cnt, bad);
    end
    bad = first_write_bad();
    tests++;
    if (obs_wa_q.size() !== 1024 || bad !== -1 || done_cnt !== 1) begin
      fails++; $display("FAIL outst_writes: got %0d writes first bad %0d done %0d expected 1024 -1 1",
                        obs_wa_q.size(), bad, done_cnt);
    end
    tests++;
    if (ram_wraddress !== 10'd1023) begin
      fails++; $display("FAIL outst_last_addr: got %0d expected 1023", ram_wraddress);
    end
  endtask

  task automatic test_busy_start();
    logic [AW-1:0] base = 24'h004000;
    int bad;
    clear_obs();
    lat = 3;
    build_expected(5, base);
    begin_load(5, base);
    repeat (4) step();
    begin_load(1, 24'h00F000);
    repeat (2) step();
    begin_load(8, 24'h00E000);
    run_to_done(500);
    tests++;
    if (err_cnt !== 0) begin
      fails++; $display("FAIL busy_start_error: got %0d error pulses expected 0", err_cnt);
    end
    bad = first_read_bad();
    tests++;
    if (acc_addr_q.size() !== 25 || bad !== -1) begin
      fails++; $display("FAIL busy_start_reads: got %0d reads first bad %0d expected 25 -1",
                        acc_addr_q.size(), bad);
    end
    bad = first_write_bad();
    tests++;
    if (obs_wa_q.size() !== 25 || bad !== -1 || done_cnt !== 1) begin
      fails++; $display("FAIL busy_start_writes: got %0d writes first bad %0d done %0d expected 25 -1 1",
                        obs_wa_q.size(), bad, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    pend_t p;
    int n = 0;
    int bad;
    logic [AW-1:0] base = 24'h020000;
    clear_obs();
    lat = 4;
    build_expected(4, base);
    begin_load(4, base);
    while (obs_wa_q.size() < 5 && n < 200) begin step(); n++; end
    tests++;
    if (obs_wa_q.size() !== 5) begin
      fails++; $display("FAIL rst_mid_prefix: got %0d writes before reset expected 5", obs_wa_q.size());
    end
    reset_n = 1'b0; #1;
    tests++;
    if ({busy, done, error, read, ram_wren} !== 5'b0 || state_dbg !== ST_IDLE) begin
      fails++; $display("FAIL rst_mid_flags: got %b st=%0d expected 00000 st=0",
                        {busy, done, error, read, ram_wren}, state_dbg);
    end
    tests++;
    if (address !== '0 || ram_wraddress !== '0 || ram_data !== '0) begin
      fails++; $display("FAIL rst_mid_values: got addr=%h wa=%h wd=%h expected 0 0 0",
                        address, ram_wraddress, ram_data);
    end
    step();
    reset_n = 1'b1;
    obs_wa_q.delete();
    obs_wd_q.delete();
    read_seen = 0;
    p.addr = base;
    p.due  = cycle_cnt;
    pend_q.push_back(p);
    repeat (8) step();
    tests++;
    if (obs_wa_q.size() !== 0 || read_seen !== 0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_stray: got writes=%0d reads=%0d busy=%b expected 0 0 0",
                        obs_wa_q.size(), read_seen, busy);
    end
    clear_obs();
    build_expected(3, 24'h030010);
    begin_load(3, 24'h030010);
    run_to_done(300);
    bad = first_write_bad();
    tests++;
    if (obs_wa_q.size() !== 9 || bad !== -1 || done_cnt !== 1) begin
      fails++; $display("FAIL rst_mid_reload: got %0d writes first bad %0d done %0d expected 9 -1 1",
                        obs_wa_q.size(), bad, done_cnt);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] base;
    int dim, bad_w, bad_r;
    for (int it = 0; it < 6; it++) begin
      clear_obs();
      rand_wait = 1;
      lat  = $urandom_range(1, 6);
      dim  = (it == 0) ? 4 : $urandom_range(2, 12);
      base = (it == 0) ? 24'hFFFFF8 : (AW'($urandom) & ~AW'(3));
      build_expected(dim, base);
      begin_load(dim, base);
      run_to_done(3000);
      bad_w = first_write_bad();
      bad_r = first_read_bad();
      tests++;
      if (obs_wa_q.size() !== dim * dim || bad_w !== -1 || bad_r !== -1 || acc_cnt !== dim * dim) begin
        fails++; $display("FAIL rand_%0d_data: dim=%0d base=%h got %0d writes (bad %0d), %0d reads (bad %0d)",
                          it, dim, base, obs_wa_q.size(), bad_w, acc_cnt, bad_r);
      end
      tests++;
      if (peak > 8 || stall_viol !== 0 || done_cnt !== 1 || err_cnt !== 0) begin
        fails++; $display("FAIL rand_%0d_proto: got peak=%0d unstable=%0d done=%0d err=%0d expected <=8 0 1 0",
                          it, peak, stall_viol, done_cnt, err_cnt);
      end
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_basic();
    test_invalid();
    test_waitrequest();
    test_outstanding();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter ADDR_W, 24, Avalon byte-address width.
REQ-002 Parameter RAM_AW, 10, RAM word-address width (32x32 = 1024 words).
REQ-003 Parameter MAX_DIMENSION, 32, largest accepted matrix dimension.
REQ-004 Parameter MAX_OUTSTANDING, 8, maximum read requests in flight.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  one-cycle load request, sampled only in IDLE.
REQ-008 base_addr  in  ADDR_W  SDRAM byte address of element [0][0], row-major order.
REQ-009 dimension  in  6  matrix side length n.
REQ-010 busy  out  1  high from start acceptance until done.
REQ-011 done  out  1  one-cycle pulse after the last RAM write.
REQ-012 error  out  1  one-cycle pulse when start is rejected.
REQ-013 address  out  ADDR_W  Avalon-MM master read address.
REQ-014 read  out  1  Avalon-MM master read request.
REQ-015 readdata  in  32  Avalon read data.
REQ-016 readdatavalid  in  1  Avalon read-data strobe.
REQ-017 waitrequest  in  1  Avalon stall for the current request.
REQ-018 ram_wraddress  out  RAM_AW  RAM write address.
REQ-019 ram_data  out  32  RAM write data.
REQ-020 ram_wren  out  1  RAM write enable.

Function
REQ-021 The block SHALL implement the states IDLE, ISSUE, DRAIN and FINISH.
REQ-022 IDLE: on start with 2 <= dimension <= MAX_DIMENSION, the block SHALL latch base_addr and N = dimension*dimension (11 bits), assert busy, and go to ISSUE.
REQ-023 IDLE: on start with an invalid dimension, the block SHALL pulse error for one cycle, stay in IDLE, and issue no reads.
REQ-024 ISSUE: read SHALL rise one cycle after acceptance, with address = base_addr.
REQ-025 read and address SHALL hold stable while waitrequest is high.
REQ-026 A request is accepted when read=1 and waitrequest=0; each acceptance SHALL advance address by 4 and increment issued.
REQ-027 read SHALL deassert when issued reaches N, or when outstanding equals MAX_OUTSTANDING; at the outstanding limit it SHALL reassert once outstanding falls.
REQ-028 outstanding SHALL be +1 on acceptance, -1 on readdatavalid, and unchanged when both occur in the same cycle.
REQ-029 Each readdatavalid SHALL produce, one cycle later: ram_wren=1, ram_data=readdata, ram_wraddress=received count; received count then increments.
REQ-030 readdatavalid SHALL be ignored in IDLE and FINISH, and when received already equals N.
REQ-031 ISSUE SHALL move to DRAIN when issued reaches N; DRAIN SHALL move to FINISH when received reaches N.
REQ-032 FINISH SHALL pulse done for one cycle, the cycle after the last ram_wren, deassert busy, and return to IDLE.
REQ-033 start SHALL be ignored while busy: no error pulse and no effect on the load in progress.
REQ-034 ram_wren SHALL be 0 in every cycle without a pending write.
REQ-035 RAM addresses SHALL run 0..N-1 with no wrap; address arithmetic SHALL be ADDR_W bits, modulo 2^ADDR_W.

Reset
REQ-036 When reset_n is low, the block SHALL immediately force state=IDLE and busy, done, error, read, ram_wren = 0.
REQ-037 When reset_n is low, the block SHALL immediately force address, ram_wraddress, ram_data and all counters = 0.
REQ-038 Reset mid-transfer SHALL abandon the load; late readdatavalid arriving after reset SHALL be discarded.

Structure
REQ-039 The state encoding and the MAX_DIMENSION, ADDR_W and RAM_AW constants SHALL live in the shared det package.
REQ-040 The block SHALL be a single module with no sub-modules; the RAM stays external.

Verification
REQ-041 Test: dimension=2, base=0x000100, zero wait, data returns 2 cycles after acceptance -> reads to 0x100/0x104/0x108/0x10C; RAM 0..3 written in order; done pulses once.
REQ-042 Test: dimension=1, then dimension=33 -> error pulses once for each start; read never asserts.
REQ-043 Test: dimension=4, waitrequest high for 3 cycles on the 2nd request -> address holds at base+4; 16 writes complete.
REQ-044 Test: dimension=32, readdatavalid withheld for 20 cycles -> outstanding peaks at 8; read drops and resumes; 1024 writes; final ram_wraddress=1023.
REQ-045 Test: start pulsed while busy -> no error pulse and no change to the load in progress.
REQ-046 Test: reset_n low after 5 writes, then a stray readdatavalid -> all outputs 0; no ram_wren; a new start completes normally.
